// File: rtl/data_types_pkg.sv
// -----------------------------------------------------------------------------
// data_types_pkg
// Shared types and sizing helpers for the matrix-vector MAC block.
//   - Fallback values for the shared WIDTH / N_ROWS / N_COLUMNS defines, used
//     only when the project-wide defines have not already been set.
//   - mvm_state_t : controller state encoding.
//   - acc_width_f : default signed accumulator width for a given operand width
//                   and column count (full product width plus growth bits, so
//                   the default width can never overflow).
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef N_ROWS
`define N_ROWS 4
`endif
`ifndef N_COLUMNS
`define N_COLUMNS 2
`endif

package data_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    EMIT,
    DONE
  } mvm_state_t;

  function automatic int acc_width_f(input int width, input int n_columns);
    return 2 * width + $clog2(n_columns) + 1;
  endfunction

  localparam int ACC_WIDTH_DEFAULT = acc_width_f(`WIDTH, `N_COLUMNS);

endpackage

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Single signed multiply-accumulate: acc <= acc + sext(a_in * x_in).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (accumulator -> 0)
//   clr        : load zero into the accumulator (has priority over en)
//   en         : accumulate the current product
//   a_in, x_in : signed WIDTH-bit operands
//   acc_out    : signed ACC_WIDTH-bit accumulator value (wraps modulo 2^ACC_WIDTH)
// -----------------------------------------------------------------------------
module mac_unit
  import data_types_pkg::*;
#(
  parameter int WIDTH     = `WIDTH,
  parameter int ACC_WIDTH = acc_width_f(`WIDTH, `N_COLUMNS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     x_in,
  output logic [ACC_WIDTH-1:0] acc_out
);

  logic signed [WIDTH-1:0]     a_s;
  logic signed [WIDTH-1:0]     x_s;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;

  assign a_s      = a_in;
  assign x_s      = x_in;
  assign prod     = a_s * x_s;
  // Size cast of a signed expression sign-extends the product.
  assign prod_ext = ACC_WIDTH'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/matrix_vector_mac.sv
// -----------------------------------------------------------------------------
// matrix_vector_mac
// Computes y[r] = sum_c A[r][c] * x[c] row by row on one shared MAC and streams
// each row result out on a valid/ready interface.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   matrix_in     : N_ROWS x N_COLUMNS signed matrix from the builder
//   matrix_valid  : builder finish flag (level); a job starts on its rising edge
//   vector_in     : N_COLUMNS signed coefficients, captured with the matrix
//   result_data   : signed dot product of row result_row
//   result_row    : row index of result_data
//   result_valid  : result_data / result_row valid, held until result_ready
//   result_ready  : downstream accepts the result
//   busy          : a job is in progress
//   done          : one-cycle pulse after the last row has been accepted
// -----------------------------------------------------------------------------
module matrix_vector_mac
  import data_types_pkg::*;
#(
  parameter int N_ROWS    = `N_ROWS,
  parameter int N_COLUMNS = `N_COLUMNS,
  parameter int WIDTH     = `WIDTH,
  parameter int ACC_WIDTH = acc_width_f(`WIDTH, `N_COLUMNS)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0] matrix_in,
  input  logic                                       matrix_valid,
  input  logic [N_COLUMNS-1:0][WIDTH-1:0]            vector_in,
  output logic [ACC_WIDTH-1:0]                       result_data,
  output logic [3:0]                                 result_row,
  output logic                                       result_valid,
  input  logic                                       result_ready,
  output logic                                       busy,
  output logic                                       done
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COLUMNS - 1);

  mvm_state_t state_q, state_d;
  logic       mv_prev_q, mv_prev_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0] mat_q, mat_d;
  logic [N_COLUMNS-1:0][WIDTH-1:0]             vec_q, vec_d;

  logic                 start;
  logic                 acc_clr;
  logic                 acc_en;
  logic [ACC_WIDTH-1:0] acc;

  // Edge register resets to 0, so a flag already high at reset release starts a job.
  assign start     = matrix_valid && !mv_prev_q && (state_q == IDLE);
  assign mv_prev_d = matrix_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mv_prev_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      mat_q     <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      mv_prev_q <= mv_prev_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mat_q     <= mat_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = MAC;
      MAC:  if (col_q == LAST_COL) state_d = EMIT;
      EMIT: if (result_ready) state_d = (row_q == LAST_ROW) ? DONE : MAC;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, row/column counters and MAC control.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      LOAD: begin
        mat_d   = matrix_in;
        vec_d   = vector_in;
        row_d   = '0;
        col_d   = '0;
        acc_clr = 1'b1;
      end
      MAC: begin
        acc_en = 1'b1;
        col_d  = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
      end
      EMIT: begin
        if (result_ready && (row_q != LAST_ROW)) begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          acc_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mac_unit #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .a_in   (mat_q[row_q][col_q]),
    .x_in   (vec_q[col_q]),
    .acc_out(acc)
  );

  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    result_valid = (state_q == EMIT);
    result_data  = acc;
    result_row   = 4'(row_q);
  end

endmodule
